// File: rtl/vga_pkg.sv
// Shared VGA definitions: framebuffer geometry for both supported resolutions
// and the write-scheduler state encoding.
package vga_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_CLEAR      = 2'd2
    } vga_state_t;

    localparam int HI_W  = 320;
    localparam int HI_H  = 240;
    localparam int HI_AW = 17;
    localparam int HI_XW = 9;
    localparam int HI_YW = 8;

    localparam int LO_W  = 160;
    localparam int LO_H  = 120;
    localparam int LO_AW = 15;
    localparam int LO_XW = 8;
    localparam int LO_YW = 7;

    function automatic int res_w(input bit low_res);
        return low_res ? LO_W : HI_W;
    endfunction

    function automatic int res_h(input bit low_res);
        return low_res ? LO_H : HI_H;
    endfunction

    function automatic int res_aw(input bit low_res);
        return low_res ? LO_AW : HI_AW;
    endfunction

    function automatic int res_xw(input bit low_res);
        return low_res ? LO_XW : HI_XW;
    endfunction

    function automatic int res_yw(input bit low_res);
        return low_res ? LO_YW : HI_YW;
    endfunction

endpackage

// File: rtl/vga_address_translator.sv
// Maps a pixel coordinate to its linear framebuffer address (y*W + x) and
// flags whether the coordinate lies inside the visible frame.
module vga_address_translator
    import vga_pkg::*;
#(
    parameter string RESOLUTION = "320x240",
    localparam bit   LOW_RES    = (RESOLUTION == "160x120"),
    localparam int   W          = res_w(LOW_RES),
    localparam int   H          = res_h(LOW_RES),
    localparam int   AW         = res_aw(LOW_RES),
    localparam int   XW         = res_xw(LOW_RES),
    localparam int   YW         = res_yw(LOW_RES)
) (
    input  logic [XW-1:0] i_x,
    input  logic [YW-1:0] i_y,
    output logic [AW-1:0] o_address,
    output logic          o_in_range
);

    logic [AW-1:0] w_row_base;

    // Out-of-range coordinates may alias; o_in_range gates their use.
    assign w_row_base = AW'(i_y) * AW'(W);
    assign o_address  = w_row_base + AW'(i_x);
    assign o_in_range = (i_x < XW'(W)) && (i_y < YW'(H));

endmodule

// File: rtl/vga_write_scheduler.sv
// Arbitrates framebuffer writes between single-pixel plots and a full-screen
// fill that starts at the next vertical blanking after it is requested.
module vga_write_scheduler
    import vga_pkg::*;
#(
    parameter string RESOLUTION              = "320x240",
    parameter int    BITS_PER_COLOUR_CHANNEL = 1,
    parameter string MONOCHROME              = "FALSE",
    localparam bit   LOW_RES = (RESOLUTION == "160x120"),
    localparam int   W       = res_w(LOW_RES),
    localparam int   H       = res_h(LOW_RES),
    localparam int   AW      = res_aw(LOW_RES),
    localparam int   XW      = res_xw(LOW_RES),
    localparam int   YW      = res_yw(LOW_RES),
    localparam int   CW      = (MONOCHROME == "TRUE") ? 1 : 3 * BITS_PER_COLOUR_CHANNEL
) (
    input  logic          vga_clock,
    input  logic          resetn,
    input  logic          frame_start,
    input  logic          plot_valid,
    output logic          plot_ready,
    input  logic [XW-1:0] plot_x,
    input  logic [YW-1:0] plot_y,
    input  logic [CW-1:0] plot_colour,
    input  logic          clear_start,
    input  logic [CW-1:0] clear_colour,
    output logic          clear_busy,
    output logic          clear_done,
    output logic [AW-1:0] mem_address,
    output logic [CW-1:0] mem_colour,
    output logic          mem_wren
);

    localparam logic [AW-1:0] LAST_ADDRESS = AW'(W * H - 1);

    vga_state_t    r_state;
    logic [CW-1:0] r_clear_colour;
    logic [AW-1:0] r_fill_count;
    logic [AW-1:0] r_mem_address;
    logic [CW-1:0] r_mem_colour;
    logic          r_mem_wren;
    logic          r_clear_done;

    logic [AW-1:0] w_plot_address;
    logic          w_plot_in_range;
    logic          w_plot_accept;

    vga_address_translator #(
        .RESOLUTION (RESOLUTION)
    ) u_plot_translator (
        .i_x        (plot_x),
        .i_y        (plot_y),
        .o_address  (w_plot_address),
        .o_in_range (w_plot_in_range)
    );

    assign plot_ready    = (r_state != ST_CLEAR);
    assign clear_busy    = (r_state != ST_IDLE);
    assign w_plot_accept = plot_valid && plot_ready;

    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            r_state        <= ST_IDLE;
            r_clear_colour <= '0;
            r_fill_count   <= '0;
            r_mem_address  <= '0;
            r_mem_colour   <= '0;
            r_mem_wren     <= 1'b0;
            r_clear_done   <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults make wren/done single-cycle pulses;
            // later assignments in this block override them for this edge.
            r_mem_wren   <= 1'b0;
            r_clear_done <= 1'b0;

            // Plots are only accepted outside CLEAR, so they never collide
            // with a fill write below.
            if (w_plot_accept && w_plot_in_range) begin
                r_mem_wren    <= 1'b1;
                r_mem_address <= w_plot_address;
                r_mem_colour  <= plot_colour;
            end

            case (r_state)
                ST_IDLE: begin
                    if (clear_start) begin
                        r_clear_colour <= clear_colour;
                        r_state        <= ST_WAIT_FRAME;
                    end
                end
                ST_WAIT_FRAME: begin
                    if (frame_start) begin
                        r_fill_count <= '0;
                        r_state      <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    r_mem_wren    <= 1'b1;
                    r_mem_address <= r_fill_count;
                    r_mem_colour  <= r_clear_colour;
                    if (r_fill_count == LAST_ADDRESS) begin
                        r_clear_done <= 1'b1;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_fill_count <= r_fill_count + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_address = r_mem_address;
    assign mem_colour  = r_mem_colour;
    assign mem_wren    = r_mem_wren;
    assign clear_done  = r_clear_done;

endmodule

// File: tb/tb_vga_write_scheduler.sv
// Directed bench for vga_write_scheduler: plots, range rejection, full fills
// at both resolutions, ignored requests and reset abort of a fill.
module tb_vga_write_scheduler;

    logic        vga_clock = 1'b0;
    logic        resetn;

    logic        frame_start, plot_valid, clear_start;
    logic [8:0]  plot_x;
    logic [7:0]  plot_y;
    logic [2:0]  plot_colour, clear_colour;
    logic        plot_ready, clear_busy, clear_done, mem_wren;
    logic [16:0] mem_address;
    logic [2:0]  mem_colour;

    logic        lo_frame_start, lo_plot_valid, lo_clear_start;
    logic [7:0]  lo_plot_x;
    logic [6:0]  lo_plot_y;
    logic [2:0]  lo_plot_colour, lo_clear_colour;
    logic        lo_plot_ready, lo_clear_busy, lo_clear_done, lo_mem_wren;
    logic [14:0] lo_mem_address;
    logic [2:0]  lo_mem_colour;

    int checks = 0;
    int errors = 0;

    always #5 vga_clock = ~vga_clock;

    vga_write_scheduler dut (
        .vga_clock    (vga_clock),
        .resetn       (resetn),
        .frame_start  (frame_start),
        .plot_valid   (plot_valid),
        .plot_ready   (plot_ready),
        .plot_x       (plot_x),
        .plot_y       (plot_y),
        .plot_colour  (plot_colour),
        .clear_start  (clear_start),
        .clear_colour (clear_colour),
        .clear_busy   (clear_busy),
        .clear_done   (clear_done),
        .mem_address  (mem_address),
        .mem_colour   (mem_colour),
        .mem_wren     (mem_wren)
    );

    vga_write_scheduler #(.RESOLUTION("160x120")) dut_lo (
        .vga_clock    (vga_clock),
        .resetn       (resetn),
        .frame_start  (lo_frame_start),
        .plot_valid   (lo_plot_valid),
        .plot_ready   (lo_plot_ready),
        .plot_x       (lo_plot_x),
        .plot_y       (lo_plot_y),
        .plot_colour  (lo_plot_colour),
        .clear_start  (lo_clear_start),
        .clear_colour (lo_clear_colour),
        .clear_busy   (lo_clear_busy),
        .clear_done   (lo_clear_done),
        .mem_address  (lo_mem_address),
        .mem_colour   (lo_mem_colour),
        .mem_wren     (lo_mem_wren)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge vga_clock);
        #1;
    endtask

    initial begin
        int bad_addr, bad_done, bad_ready, wren_seen, lo_count, lo_last, lo_done, lo_bad, budget;

        resetn = 1'b0;
        frame_start = 1'b0; plot_valid = 1'b0; clear_start = 1'b0;
        plot_x = '0; plot_y = '0; plot_colour = '0; clear_colour = '0;
        lo_frame_start = 1'b0; lo_plot_valid = 1'b0; lo_clear_start = 1'b0;
        lo_plot_x = '0; lo_plot_y = '0; lo_plot_colour = '0; lo_clear_colour = '0;

        repeat (3) tick();
        check("rst_wren", mem_wren, 0);
        check("rst_addr", mem_address, 0);
        check("rst_colour", mem_colour, 0);
        check("rst_done", clear_done, 0);
        check("rst_busy", clear_busy, 0);
        check("rst_ready", plot_ready, 1);
        resetn = 1'b1;
        tick();

        // Basic plot: 2*320+5 = 645
        plot_valid = 1'b1; plot_x = 9'd5; plot_y = 8'd2; plot_colour = 3'b101;
        check("plot_ready_idle", plot_ready, 1);
        tick();
        plot_valid = 1'b0;
        check("plot_wren", mem_wren, 1);
        check("plot_addr", mem_address, 645);
        check("plot_colour", mem_colour, 3'b101);
        tick();
        check("idle_no_wren", mem_wren, 0);

        // Out-of-range plots are consumed without writing
        plot_valid = 1'b1; plot_x = 9'd320; plot_y = 8'd0; plot_colour = 3'b111;
        check("oor_x_ready", plot_ready, 1);
        tick();
        check("oor_x_no_wren", mem_wren, 0);
        plot_x = 9'd0; plot_y = 8'd240;
        tick();
        plot_valid = 1'b0;
        check("oor_y_no_wren", mem_wren, 0);

        // Back-to-back plots, first and last pixel
        plot_valid = 1'b1; plot_x = 9'd0; plot_y = 8'd0; plot_colour = 3'b111;
        tick();
        check("b2b0_addr", mem_address, 0);
        check("b2b0_wren", mem_wren, 1);
        plot_x = 9'd319; plot_y = 8'd239; plot_colour = 3'b001;
        tick();
        plot_valid = 1'b0;
        check("b2b1_addr", mem_address, 76799);
        check("b2b1_colour", mem_colour, 3'b001);
        check("b2b1_wren", mem_wren, 1);

        // clear_start together with a plot in IDLE: both happen (1*320+1 = 321)
        clear_start = 1'b1; clear_colour = 3'b010;
        plot_valid = 1'b1; plot_x = 9'd1; plot_y = 8'd1; plot_colour = 3'b011;
        tick();
        clear_start = 1'b0; plot_valid = 1'b0;
        check("combo_wren", mem_wren, 1);
        check("combo_addr", mem_address, 321);
        check("combo_colour", mem_colour, 3'b011);
        check("combo_busy", clear_busy, 1);

        // Second clear_start while busy must not change the latched colour
        clear_start = 1'b1; clear_colour = 3'b111;
        tick();
        clear_start = 1'b0;
        check("wait_busy", clear_busy, 1);
        check("wait_no_wren", mem_wren, 0);

        // Plotting still works while waiting for the frame (addr 10)
        plot_valid = 1'b1; plot_x = 9'd10; plot_y = 8'd0; plot_colour = 3'b110;
        check("wait_ready", plot_ready, 1);
        tick();
        plot_valid = 1'b0;
        check("wait_plot_addr", mem_address, 10);
        check("wait_plot_wren", mem_wren, 1);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("wait_ready_loop", plot_ready, 1);
        end

        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("clear_entry_ready", plot_ready, 0);
        check("clear_entry_busy", clear_busy, 1);
        check("clear_entry_no_wren", mem_wren, 0);

        // Plots requested during the fill must be held off
        plot_valid = 1'b1; plot_x = 9'd2; plot_y = 8'd0; plot_colour = 3'b111;
        bad_addr = 0; bad_done = 0; bad_ready = 0;
        for (int i = 0; i < 76800; i++) begin
            tick();
            if (mem_wren !== 1'b1 || mem_address !== 17'(i) || mem_colour !== 3'b010) bad_addr++;
            if (clear_done !== (i == 76799)) bad_done++;
            if (plot_ready !== (i == 76799)) bad_ready++;
        end
        plot_valid = 1'b0;
        check("fill_addr_errs", bad_addr, 0);
        check("fill_done_errs", bad_done, 0);
        check("fill_ready_errs", bad_ready, 0);
        check("fill_last_addr", mem_address, 76799);
        check("fill_end_busy", clear_busy, 0);
        tick();
        check("post_fill_wren", mem_wren, 0);
        check("post_fill_done", clear_done, 0);

        // clear_start and frame_start together: frame pulse ignored
        clear_start = 1'b1; frame_start = 1'b1; clear_colour = 3'b100;
        tick();
        clear_start = 1'b0; frame_start = 1'b0;
        check("same_cycle_busy", clear_busy, 1);
        check("same_cycle_no_wren", mem_wren, 0);
        wren_seen = 0;
        repeat (5) begin
            tick();
            if (mem_wren !== 1'b0) wren_seen++;
        end
        check("same_cycle_idle_writes", wren_seen, 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("fill2_entry_no_wren", mem_wren, 0);
        tick();
        check("fill2_first_wren", mem_wren, 1);
        check("fill2_first_addr", mem_address, 0);
        check("fill2_first_colour", mem_colour, 3'b100);
        repeat (1000) tick();
        check("fill2_at_1000", mem_address, 1000);

        // Reset in the middle of the fill aborts it
        #2;
        resetn = 1'b0;
        #1;
        check("abort_wren", mem_wren, 0);
        check("abort_done", clear_done, 0);
        check("abort_busy", clear_busy, 0);
        check("abort_addr", mem_address, 0);
        tick();
        resetn = 1'b1;
        wren_seen = 0; bad_done = 0;
        repeat (4) begin
            tick();
            if (mem_wren !== 1'b0 || clear_busy !== 1'b0) wren_seen++;
            if (clear_done !== 1'b0) bad_done++;
        end
        check("abort_quiet", wren_seen, 0);
        check("abort_no_done", bad_done, 0);

        // 160x120 build: plot at 2*160+5 = 325, range check at x=160
        lo_plot_valid = 1'b1; lo_plot_x = 8'd5; lo_plot_y = 7'd2; lo_plot_colour = 3'b110;
        tick();
        check("lo_plot_addr", lo_mem_address, 325);
        check("lo_plot_wren", lo_mem_wren, 1);
        lo_plot_x = 8'd160; lo_plot_y = 7'd0;
        tick();
        lo_plot_valid = 1'b0;
        check("lo_oor_no_wren", lo_mem_wren, 0);

        lo_clear_start = 1'b1; lo_clear_colour = 3'b001;
        tick();
        lo_clear_start = 1'b0;
        lo_frame_start = 1'b1;
        tick();
        lo_frame_start = 1'b0;
        lo_count = 0; lo_last = -1; lo_done = 0; lo_bad = 0; budget = 0;
        while (lo_done == 0 && budget < 20100) begin
            tick();
            budget++;
            if (lo_mem_wren === 1'b1) begin
                if (lo_mem_address !== 15'(lo_count) || lo_mem_colour !== 3'b001) lo_bad++;
                lo_count++;
                lo_last = int'(lo_mem_address);
            end
            if (lo_clear_done === 1'b1) lo_done++;
        end
        check("lo_fill_done_seen", lo_done, 1);
        check("lo_fill_count", lo_count, 19200);
        check("lo_fill_last_addr", lo_last, 19199);
        check("lo_fill_seq_errs", lo_bad, 0);
        check("lo_fill_end_busy", lo_clear_busy, 0);
        tick();
        check("lo_post_fill_wren", lo_mem_wren, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
